// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer
// Receives PS/2 keyboard frames and turns them into tagged scan codes.
// The PS/2 clock and data pins are synchronized. Bits are sampled on falling
// edges of the PS/2 clock. Each 11-bit frame is checked. The E0 (extended)
// and F0 (break) prefixes are folded into flags on the following code. Each
// code is offered downstream on a valid/ready handshake.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-low reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   code_rdy   in   downstream accepts the code this cycle
//   code       out  scan code with prefixes stripped
//   code_vld   out  code/is_break/is_ext valid; held until accepted
//   is_break   out  code was preceded by F0
//   is_ext     out  code was preceded by E0
//   frame_err  out  one-cycle pulse: bad start/stop/parity or timeout
//   overrun    out  one-cycle pulse: completed code dropped, output still full
//   busy       out  high while a frame is being shifted in
module ps2_rx_sequencer #(
  parameter int TIMEOUT_CYC = 5000,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       code_rdy,
  output logic [7:0] code,
  output logic       code_vld,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // Odd parity: the data bits and the parity bit together hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic             c1_q, c2_q, c3_q;
  logic             d1_q, d2_q;
  state_t           state_q;
  logic [10:0]      sr_q;
  logic [3:0]       bit_cnt_q;
  logic [CNT_W-1:0] tmo_q;
  logic             ext_q, brk_q;
  logic [7:0]       code_q;
  logic             code_vld_q, is_break_q, is_ext_q;
  logic             frame_err_q, overrun_q, busy_q;

  logic             fall_s;
  logic [7:0]       data_s;
  logic             frame_ok_s;
  logic             can_load_s;

  // The third clock flop gives an edge detector. It compares two settled samples.
  assign fall_s = c3_q & ~c2_q;

  // Bits enter at the MSB. After 11 shifts the start bit sits at index 0.
  assign data_s     = sr_q[8:1];
  assign frame_ok_s = (sr_q[0] == 1'b0) && (sr_q[10] == 1'b1) && odd_parity_ok(data_s, sr_q[9]);
  assign can_load_s = !code_vld_q || code_rdy;

  // Pin synchronizers. They idle high, like the PS/2 bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c1_q <= 1'b1;
      c2_q <= 1'b1;
      c3_q <= 1'b1;
      d1_q <= 1'b1;
      d2_q <= 1'b1;
    end else begin
      c1_q <= ps2_clk;
      c2_q <= c1_q;
      c3_q <= c2_q;
      d1_q <= ps2_data;
      d2_q <= d1_q;
    end
  end

  // Reception FSM, prefix tracking and registered output handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= 11'd0;
      bit_cnt_q   <= 4'd0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      code_q      <= 8'd0;
      code_vld_q  <= 1'b0;
      is_break_q  <= 1'b0;
      is_ext_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A completed transfer empties the output. An emit below overrides this.
      if (code_vld_q && code_rdy) begin
        code_vld_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall_s && !d2_q) begin
            sr_q      <= {d2_q, sr_q[10:1]};
            bit_cnt_q <= 4'd1;
            tmo_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          if (fall_s) begin
            sr_q      <= {d2_q, sr_q[10:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            tmo_q     <= '0;
            // A falling edge while bit_cnt is 10 carries the stop bit.
            if (bit_cnt_q == 4'd10) begin
              busy_q  <= 1'b0;
              state_q <= CHECK;
            end
          end else if (tmo_q == TMO_LAST) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end

        CHECK: begin
          state_q <= IDLE;
          if (!frame_ok_s) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
          end else if (data_s == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (data_s == 8'hF0) begin
            brk_q <= 1'b1;
          end else begin
            if (can_load_s) begin
              code_q     <= data_s;
              is_break_q <= brk_q;
              is_ext_q   <= ext_q;
              code_vld_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign code      = code_q;
  assign code_vld  = code_vld_q;
  assign is_break  = is_break_q;
  assign is_ext    = is_ext_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// Scoreboard bench for ps2_rx_sequencer. The stimulus pushes the expected codes.
// A negedge monitor pops and compares on every accepted transfer.
module tb_ps2_rx_sequencer;

  localparam int TMO  = 5000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_rdy = 1'b0;
  logic [7:0] code;
  logic       code_vld, is_break, is_ext, frame_err, overrun, busy;

  ps2_rx_sequencer #(.TIMEOUT_CYC(TMO), .CNT_W(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code_rdy (code_rdy),
    .code     (code),
    .code_vld (code_vld),
    .is_break (is_break),
    .is_ext   (is_ext),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_cnt  = 0;
  int   ovr_cnt  = 0;
  logic prev_hold = 1'b0;
  exp_t prev_out;

  // Monitor: transfers, hold stability, error/overrun pulse counting.
  always @(negedge clk) begin
    exp_t got, want;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      got = {code, is_break, is_ext};
      if (prev_hold) begin
        n_checks++;
        if (!code_vld || got != prev_out) begin
          n_fail++;
          $display("FAIL hold: vld=%0b out=%h required held %h", code_vld, got, prev_out);
        end
      end
      if (frame_err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (code_vld && code_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_code: got code=%h brk=%0b ext=%0b, none required", code, is_break, is_ext);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            n_fail++;
            $display("FAIL code: got code=%h brk=%0b ext=%0b required code=%h brk=%0b ext=%0b",
                     code, is_break, is_ext, want.c, want.b, want.e);
          end
        end
      end
      prev_hold = code_vld && !code_rdy;
      prev_out  = got;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic send(input logic [7:0] d, input logic bad_par);
    send_bits(frame(d, bad_par), 11);
  endtask

  task automatic expect_code(input logic [7:0] c, input logic b, input logic e);
    exp_q.push_back({c, b, e});
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      cyc(1);
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"}, code, 0);
    chk({tag, "_vld"}, code_vld, 0);
    chk({tag, "_brk"}, is_break, 0);
    chk({tag, "_ext"}, is_ext, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk_all_zero("reset");
    code_rdy = 1'b1;

    // 1: plain make code
    expect_code(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);
    drain();
    chk("t1_err", err_cnt, 0);
    cyc(2);
    chk("t1_vld_drop", code_vld, 0);

    // 2: break prefix, then a plain code with the flag cleared
    expect_code(8'h1C, 1'b1, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    expect_code(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);
    drain();

    // 3: extended break
    expect_code(8'h75, 1'b1, 1'b1);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    drain();
    chk("t3_err", err_cnt, 0);

    // 4: parity error, then timeout, then recovery
    send(8'h1C, 1'b1);
    chk("t4_par_err", err_cnt, 1);
    chk("t4_no_vld", code_vld, 0);
    send_bits(frame(8'h5A, 1'b0), 5);
    chk("t4_busy_mid", busy, 1);
    cyc(TMO + 50);
    chk("t4_tmo_err", err_cnt, 2);
    chk("t4_busy_drop", busy, 0);
    expect_code(8'h29, 1'b0, 1'b0);
    send(8'h29, 1'b0);
    drain();

    // 5: overrun while output is held
    code_rdy = 1'b0;
    expect_code(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h32, 1'b0);
    chk("t5_vld_held", code_vld, 1);
    chk("t5_code_held", code, 8'h1C);
    chk("t5_ovr", ovr_cnt, 1);
    code_rdy = 1'b1;
    drain();
    cyc(2);
    chk("t5_vld_drop", code_vld, 0);

    // 6: reset mid-frame, then a fresh frame
    send_bits(frame(8'h5A, 1'b0), 7);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk_all_zero("t6_reset");
    expect_code(8'h45, 1'b0, 1'b0);
    send(8'h45, 1'b0);
    drain();
    chk("t6_err", err_cnt, 2);
    chk("t6_ovr", ovr_cnt, 1);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_sequencer.md
Name: ps2_rx_sequencer

Overview:
Controller that sequences PS/2 keyboard reception. It detects falling edges of the PS/2 clock, shifts in and checks each 11-bit frame, and resolves the E0 (extended) and F0 (break) prefixes into one tagged scan code. Each code is delivered to the downstream display/decode path over a valid/ready handshake. It replaces free-running enable sequencing at the front of the keyboard datapath and reports frame errors and overruns as one-cycle pulses.

Parameters:
TIMEOUT_CYC, 5000, max clk cycles allowed between PS/2 clock falling edges inside a frame (100 us at 50 MHz)
CNT_W, 13, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
code_rdy  in  1  downstream accepts code this cycle
code  out  8  scan code (prefixes stripped)
code_vld  out  1  code/is_break/is_ext valid; held until accepted
is_break  out  1  code was preceded by F0
is_ext  out  1  code was preceded by E0
frame_err  out  1  one-cycle pulse: bad start/stop/parity or timeout
overrun  out  1  one-cycle pulse: completed code dropped because output still full
busy  out  1  high while a frame is being shifted

Behaviour:
- Reset is sampled on clk rising edge while rst=0.
- Reset values: code=0, code_vld=0, is_break=0, is_ext=0, frame_err=0, overrun=0, busy=0. Synchronizers reset to 1, FSM goes to IDLE, prefix flags are cleared, and the bit counter and timeout counter are 0.
- Synchronization: ps2_clk passes through 3 flops (c1,c2,c3) and ps2_data through 2 flops (d1,d2). fall = c3 & ~c2. On each fall the sampled bit is d2.
- Frame format: bit0 start=0; bits1-8 data, LSB first; bit9 odd parity (XOR of data and parity bit = 1); bit10 stop=1.
- FSM states and transitions:
  - IDLE: on fall with d2=0, store the start bit, set bit_cnt=1, and go to SHIFT. A fall with d2=1 is ignored.
  - SHIFT: busy=1. Each fall shifts d2 in and increments bit_cnt. The timeout counter clears on each fall and otherwise increments. If the counter reaches TIMEOUT_CYC, pulse frame_err, clear the prefix flags, and go to IDLE. When the bit10 fall occurs, go to CHECK.
  - CHECK (1 cycle): validate start, stop and parity. On failure, pulse frame_err, clear the prefix flags, and go to IDLE. On success:
    - data=E0: set ext flag.
    - data=F0: set brk flag.
    - otherwise: emit the code, then clear both flags.
    - Go to IDLE in all success cases.
- Emit:
  - If code_vld=0, or code_vld=1 with code_rdy=1 in the same cycle: on the next clk, code=data, is_break=brk flag, is_ext=ext flag, code_vld=1. Latency is 1 cycle after CHECK.
  - If code_vld=1 and code_rdy=0: the new code is dropped, overrun pulses for 1 cycle, the held output is unchanged, and the flags are still cleared.
- Handshake: the transfer occurs in a cycle with code_vld=1 and code_rdy=1. code_vld drops the next cycle unless a new emit coincides. code, is_break and is_ext must stay stable while code_vld=1 and not yet accepted.
- Multiple prefixes: E0 then F0 sets both flags. A repeated identical prefix is idempotent.
- A fall arriving during CHECK is ignored (the protocol never produces one).
- Reset mid-frame or mid-handshake: all state is abandoned immediately, code_vld=0, and the partial frame is discarded. After reset, the next start bit begins a fresh frame.

Test Plan:
1. Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity=0; stop=1) with code_rdy=1 -> exactly one code_vld pulse, code=0x1C, is_break=0, is_ext=0, frame_err never asserted.
2. Frames F0 then 1C -> no output after F0; one output code=0x1C, is_break=1, is_ext=0. A following plain 1C outputs is_break=0.
3. Frames E0, F0, 75 (parity=0) -> single output code=0x75, is_ext=1, is_break=1.
4. Frame 0x1C with parity=1 -> frame_err high 1 cycle, no code_vld. Then a 5-bit partial frame followed by TIMEOUT_CYC idle cycles -> frame_err pulse, busy drops. A next good 0x29 frame yields code=0x29.
5. code_rdy=0, frames 0x1C then 0x32 -> code=0x1C held with code_vld=1, overrun pulses once at the 0x32 emit. Raising code_rdy gives one transfer of 0x1C, then code_vld=0.
6. Pull rst=0 for 1 cycle after bit 6 of a frame, then send a full 0x45 frame -> all outputs 0 after reset, and only code=0x45 is emitted with no frame_err.
